// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART ALU frontend: opcode characters, ALU select
// codes, FSM state encoding and status byte layout.
package uart_alu_pkg;

    localparam logic [7:0] ASCII_ADD = 8'd43;   // '+'
    localparam logic [7:0] ASCII_SUB = 8'd45;   // '-'
    localparam logic [7:0] ASCII_AND = 8'd38;   // '&'
    localparam logic [7:0] ASCII_OR  = 8'd124;  // '|'
    localparam logic [7:0] ASCII_XOR = 8'd94;   // '^'

    localparam int ALU_SEL_W = 6;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 6'b100000;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 6'b100010;
    localparam logic [ALU_SEL_W-1:0] ALU_AND = 6'b100100;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 6'b100101;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR = 6'b100110;
    localparam logic [ALU_SEL_W-1:0] ALU_NOP = 6'b000000;

    localparam logic [2:0] ST_RX_A    = 3'd0;
    localparam logic [2:0] ST_RX_OP   = 3'd1;
    localparam logic [2:0] ST_RX_B    = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_TX_LOAD = 3'd4;
    localparam logic [2:0] ST_TX_WAIT = 3'd5;

    typedef enum logic [2:0] {
        RX_A    = ST_RX_A,
        RX_OP   = ST_RX_OP,
        RX_B    = ST_RX_B,
        EXEC    = ST_EXEC,
        TX_LOAD = ST_TX_LOAD,
        TX_WAIT = ST_TX_WAIT
    } state_t;

    localparam int STAT_INVALID = 0;
    localparam int STAT_CARRY   = 1;

    typedef struct packed {
        logic                 valid;
        logic [ALU_SEL_W-1:0] sel;
    } op_decode_t;

    // Unknown characters map to a select code the ALU treats as "result 0".
    function automatic op_decode_t decode_opcode(input logic [7:0] code);
        op_decode_t d;
        d.valid = 1'b1;
        case (code)
            ASCII_ADD: d.sel = ALU_ADD;
            ASCII_SUB: d.sel = ALU_SUB;
            ASCII_AND: d.sel = ALU_AND;
            ASCII_OR:  d.sel = ALU_OR;
            ASCII_XOR: d.sel = ALU_XOR;
            default: begin
                d.valid = 1'b0;
                d.sel   = ALU_NOP;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_alu_frontend_alu_core.sv
// Combinational ALU: NB_OP-bit wrap-around arithmetic and bitwise logic with
// carry/borrow taken from bit NB_OP of a widened compute.
module alu_core
    import uart_alu_pkg::*;
#(
    parameter int NB_OP  = 16,
    parameter int NB_OPE = 6
) (
    input  logic [NB_OP-1:0]  a,
    input  logic [NB_OP-1:0]  b,
    input  logic [NB_OPE-1:0] sel,
    output logic [NB_OP-1:0]  result,
    output logic              carry
);

    logic [NB_OP:0] wide;

    always_comb begin
        wide = '0;
        case (sel)
            NB_OPE'(ALU_ADD): wide = {1'b0, a} + {1'b0, b};
            NB_OPE'(ALU_SUB): wide = {1'b0, a} - {1'b0, b};
            NB_OPE'(ALU_AND): wide = {1'b0, a & b};
            NB_OPE'(ALU_OR):  wide = {1'b0, a | b};
            NB_OPE'(ALU_XOR): wide = {1'b0, a ^ b};
            default:          wide = '0;
        endcase
        result = wide[NB_OP-1:0];
        carry  = wide[NB_OP];
    end

endmodule

// File: rtl/uart_alu_frontend.sv
// UART-to-ALU frame controller: A, opcode, B in; result bytes and status out.
// Optional inter-byte timeout abort is enabled by defining UART_ALU_TIMEOUT_EN.
module uart_alu_frontend
    import uart_alu_pkg::*;
#(
    parameter int NB_BITS        = 8,
    parameter int N_BYTES        = 2,
    parameter int NB_OPE         = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic [NB_BITS-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err
);

    localparam int NB_OP = NB_BITS * N_BYTES;
    localparam int CNT_W = $clog2(N_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(N_BYTES);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_alu_frontend: TIMEOUT_CYCLES must be at least 2");
    end

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [NB_OP-1:0]   a_q;
    logic [NB_OP-1:0]   b_q;
    logic [NB_BITS-1:0] opcode_q;
    logic [NB_OP-1:0]   result_q;
    logic [NB_BITS-1:0] status_q;
    logic               rx_prev;
    logic               tx_prev;

    logic               rx_edge;
    logic               tx_edge;
    op_decode_t         dec;
    logic [NB_OP-1:0]   alu_result;
    logic               alu_carry;
    logic [NB_OP-1:0]   exec_result;
    logic [NB_BITS-1:0] exec_status;
    logic [CNT_W-1:0]   tx_next_idx;
    logic [NB_BITS-1:0] tx_next;

    assign rx_edge = i_rx_done & ~rx_prev;
    assign tx_edge = i_tx_done & ~tx_prev;
    assign dec     = decode_opcode(opcode_q[7:0]);

    alu_core #(
        .NB_OP  (NB_OP),
        .NB_OPE (NB_OPE)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .sel    (NB_OPE'(dec.sel)),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Byte idx of a result word, MSB-first.
    function automatic logic [NB_BITS-1:0] pick_byte(input logic [NB_OP-1:0] word,
                                                     input int idx);
        logic [NB_OP-1:0] shifted;
        shifted = word >> ((N_BYTES - 1 - idx) * NB_BITS);
        return shifted[NB_BITS-1:0];
    endfunction

    always_comb begin
        exec_result               = dec.valid ? alu_result : '0;
        exec_status               = '0;
        exec_status[STAT_INVALID] = ~dec.valid;
        exec_status[STAT_CARRY]   = dec.valid & alu_carry;
    end

    // Byte to send after the one currently in flight; the last slot is status.
    always_comb begin
        tx_next_idx = byte_cnt + CNT_W'(1);
        if (tx_next_idx == LAST_TX) begin
            tx_next = status_q;
        end else begin
            tx_next = pick_byte(result_q, int'(tx_next_idx));
        end
    end

`ifdef UART_ALU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;
    logic            partial;
    logic            accepting;

    assign partial   = ((state == RX_A) && (byte_cnt != '0)) ||
                       (state == RX_OP) || (state == RX_B);
    assign accepting = rx_edge && (state inside {RX_A, RX_OP, RX_B});
`endif

    // NOTE: reset is synchronous, so it lives inside the clocked branch; all
    // state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= RX_A;
            byte_cnt   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            opcode_q   <= '0;
            result_q   <= '0;
            status_q   <= '0;
            rx_prev    <= 1'b0;
            tx_prev    <= 1'b0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
`ifdef UART_ALU_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
        end else begin
            rx_prev    <= i_rx_done;
            tx_prev    <= i_tx_done;
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;

            case (state)
                RX_A: begin
                    if (rx_edge) begin
                        a_q    <= (a_q << NB_BITS) | NB_OP'(i_rx_data);
                        o_busy <= 1'b1;
                        if (byte_cnt == LAST_RX) begin
                            byte_cnt <= '0;
                            state    <= RX_OP;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                RX_OP: begin
                    if (rx_edge) begin
                        opcode_q <= i_rx_data;
                        state    <= RX_B;
                    end
                end
                RX_B: begin
                    if (rx_edge) begin
                        b_q <= (b_q << NB_BITS) | NB_OP'(i_rx_data);
                        if (byte_cnt == LAST_RX) begin
                            byte_cnt <= '0;
                            state    <= EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                EXEC: begin
                    // First result byte goes straight from the ALU so the
                    // start pulse lands in the TX_LOAD cycle.
                    result_q   <= exec_result;
                    status_q   <= exec_status;
                    o_tx_data  <= pick_byte(exec_result, 0);
                    o_tx_start <= 1'b1;
                    byte_cnt   <= '0;
                    state      <= TX_LOAD;
                end
                TX_LOAD: begin
                    state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_edge) begin
                        if (byte_cnt == LAST_TX) begin
                            byte_cnt <= '0;
                            o_busy   <= 1'b0;
                            state    <= RX_A;
                        end else begin
                            byte_cnt   <= tx_next_idx;
                            o_tx_data  <= tx_next;
                            o_tx_start <= 1'b1;
                            state      <= TX_LOAD;
                        end
                    end
                end
                default: state <= RX_A;
            endcase

`ifdef UART_ALU_TIMEOUT_EN
            if (accepting || !partial) begin
                idle_cnt <= '0;
            end else if (idle_cnt == TO_LAST) begin
                idle_cnt <= '0;
                byte_cnt <= '0;
                a_q      <= '0;
                b_q      <= '0;
                o_busy   <= 1'b0;
                o_err    <= 1'b1;
                state    <= RX_A;
            end else begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_alu_frontend.sv
// Self-checking bench for uart_alu_frontend: directed frames from the test plan
// plus randomized frames compared against an arithmetic reference model.
module tb_uart_alu_frontend;

    localparam int NB_BITS        = 8;
    localparam int N_BYTES        = 2;
    localparam int NB_OPE         = 6;
    localparam int TIMEOUT_CYCLES = 40;
    localparam int NB_OP          = NB_BITS * N_BYTES;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic [NB_BITS-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_BITS-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_err;

    int checks    = 0;
    int failures  = 0;
    int start_cnt = 0;
    int err_cnt   = 0;

    logic [7:0] exp_q[$];

    uart_alu_frontend #(
        .NB_BITS        (NB_BITS),
        .N_BYTES        (N_BYTES),
        .NB_OPE         (NB_OPE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_tx_start) start_cnt++;
        if (o_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model_push(input longint a, input longint b, input logic [7:0] op);
        longint modulus;
        longint r;
        int     st;
        modulus = longint'(1) << NB_OP;
        st = 0;
        case (op)
            8'd43:  begin r = a + b; if (r >= modulus) st = 2; r = r % modulus; end
            8'd45:  begin r = (a - b + modulus) % modulus; if (a < b) st = 2; end
            8'd38:  r = a & b;
            8'd124: r = a | b;
            8'd94:  r = a ^ b;
            default: begin r = 0; st = 1; end
        endcase
        for (int k = N_BYTES - 1; k >= 0; k--) exp_q.push_back(8'((r >> (8 * k)) & 255));
        exp_q.push_back(8'(st));
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit last);
        @(negedge i_clk);
        i_rx_done = 1'b0;
        @(negedge i_clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        if (!last) begin
            @(negedge i_clk);
            i_rx_done = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end
    endtask

    task automatic send_frame(input logic [NB_OP-1:0] a, input logic [7:0] op,
                              input logic [NB_OP-1:0] b);
        model_push(longint'(a), longint'(b), op);
        check("busy_idle_before_frame", o_busy, 1'b0);
        send_byte(a[15:8], 1'b0);
        check("busy_after_first_byte", o_busy, 1'b1);
        send_byte(a[7:0], 1'b0);
        send_byte(op, 1'b0);
        send_byte(b[15:8], 1'b0);
        send_byte(b[7:0], 1'b1);
    endtask

    // Acts as the TX core; optionally throws rx_done edges at the DUT meanwhile.
    task automatic collect_response(input bit inject);
        int base;
        base = start_cnt;
        for (int k = 0; k <= N_BYTES; k++) begin
            int         waited;
            bit         found;
            logic [7:0] d;
            logic [7:0] e;
            waited = 0;
            found  = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge i_clk);
                i_rx_done = 1'b0;
                i_tx_done = 1'b0;
                waited++;
                if (o_tx_start) begin
                    found = 1'b1;
                    break;
                end
            end
            check("tx_start_seen", found, 1'b1);
            check(k == 0 ? "first_start_latency" : "next_start_latency",
                  waited, (k == 0) ? 2 : 1);
            e = exp_q.pop_front();
            d = o_tx_data;
            check($sformatf("tx_byte%0d", k), d, e);
            check("busy_during_tx", o_busy, 1'b1);
            for (int h = 0; h < 4; h++) begin
                @(negedge i_clk);
                if (inject) begin
                    i_rx_done = (h % 2 == 0);
                    i_rx_data = 8'($urandom);
                end
            end
            check("tx_data_stable", o_tx_data, d);
            check("no_start_while_waiting", o_tx_start, 1'b0);
            @(negedge i_clk);
            i_tx_done = 1'b1;
            if (inject) begin
                i_rx_done = 1'b1;
                i_rx_data = 8'($urandom);
            end
        end
        @(negedge i_clk);
        i_tx_done = 1'b0;
        i_rx_done = 1'b0;
        check("busy_low_after_last_tx", o_busy, 1'b0);
        repeat (10) @(negedge i_clk);
        check("start_pulse_count", start_cnt - base, N_BYTES + 1);
    endtask

    initial begin
        bit          found;
        bit          err_seen;
        int          base_s;
        int          base_e;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [7:0]  rop;

        i_rst     = 1'b1;
        i_rx_data = '0;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_tx_data", o_tx_data, 8'h00);
        check("reset_tx_start", o_tx_start, 1'b0);
        check("reset_busy", o_busy, 1'b0);
        check("reset_err", o_err, 1'b0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        send_frame(16'h1234, 8'd43, 16'h0101);
        collect_response(1'b0);

        send_frame(16'h0001, 8'd45, 16'h0002);
        collect_response(1'b0);

        send_frame(16'hF00F, 8'd42, 16'h1234);
        collect_response(1'b0);

        base_s = start_cnt;
        base_e = err_cnt;
`ifdef UART_ALU_TIMEOUT_EN
        send_byte(8'h12, 1'b0);
        send_byte(8'd43, 1'b0);
        found = 1'b0;
        for (int c = 0; c < TIMEOUT_CYCLES + 20; c++) begin
            @(negedge i_clk);
            if (o_err) begin
                found = 1'b1;
                break;
            end
        end
        check("timeout_err_seen", found, 1'b1);
        repeat (5) @(negedge i_clk);
        check("timeout_err_single_pulse", err_cnt - base_e, 1);
        check("timeout_no_tx", start_cnt - base_s, 0);
        check("timeout_busy_low", o_busy, 1'b0);
`else
        send_byte(8'h12, 1'b0);
        send_byte(8'd43, 1'b0);
        err_seen = 1'b0;
        repeat (3 * TIMEOUT_CYCLES) begin
            @(negedge i_clk);
            if (o_err) err_seen = 1'b1;
        end
        check("no_timeout_err", err_seen, 1'b0);
        check("partial_frame_busy", o_busy, 1'b1);
        check("partial_frame_no_tx", start_cnt - base_s, 0);
        model_push(64'h122B, 64'h0F0F, 8'd38);
        send_byte(8'd38, 1'b0);
        send_byte(8'h0F, 1'b0);
        send_byte(8'h0F, 1'b1);
        collect_response(1'b0);
`endif

        send_frame(16'h0005, 8'd124, 16'h000A);
        collect_response(1'b0);

        send_frame(16'hA5C3, 8'd94, 16'h0FF0);
        collect_response(1'b1);

        send_frame(16'hABCD, 8'd43, 16'h1111);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge i_clk);
            i_rx_done = 1'b0;
            if (o_tx_start) begin
                found = 1'b1;
                break;
            end
        end
        check("pre_reset_start_seen", found, 1'b1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midtx_reset_tx_data", o_tx_data, 8'h00);
        check("midtx_reset_tx_start", o_tx_start, 1'b0);
        check("midtx_reset_busy", o_busy, 1'b0);
        check("midtx_reset_err", o_err, 1'b0);
        i_rst = 1'b0;
        exp_q.delete();
        base_s = start_cnt;
        @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        repeat (20) @(negedge i_clk);
        check("no_start_after_reset", start_cnt - base_s, 0);

        send_frame(16'h8000, 8'd43, 16'h8000);
        collect_response(1'b0);

        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 5))
                0: rop = 8'd43;
                1: rop = 8'd45;
                2: rop = 8'd38;
                3: rop = 8'd124;
                4: rop = 8'd94;
                default: rop = 8'($urandom);
            endcase
            send_frame(ra, rop, rb);
            collect_response(i % 3 == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
